// File: rtl/quicksort_pkg.sv
// Shared sizes, FSM/stack types and reset-time array contents for the
// quicksort core and its dual-port RAM.
package quicksort_pkg;
  localparam int N      = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int SP_W   = 6;

  // Slave-visible base of the data array; the stack base is private.
  localparam logic [6:0] MEM_var_28860_28869 = 7'd32;
  localparam logic [6:0] MEM_var_29139_28866 = 7'd32;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_PUSH_INIT  = 4'd1,
    ST_POP        = 4'd2,
    ST_PART_SETUP = 4'd3,
    ST_PART_LOOP  = 4'd4,
    ST_SWAP       = 4'd5,
    ST_PART_END   = 4'd6,
    ST_PUSH_SUB   = 4'd7,
    ST_DONE       = 4'd8
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] lo;
    logic [ADDR_W-1:0] hi;
  } stack_entry_t;

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] idx);
    logic [15:0] prod;
    prod = 16'd90 + (16'd37 * {11'd0, idx});
    return prod[DATA_W-1:0];
  endfunction

  // Byte lane mask for an access of size_bits bits, saturating at 8.
  function automatic logic [DATA_W-1:0] size_mask(input logic [3:0] size_bits);
    logic [DATA_W-1:0] m;
    if (size_bits >= 4'd8) begin
      m = 8'hFF;
    end else begin
      m = (8'd1 << size_bits) - 8'd1;
    end
    return m;
  endfunction
endpackage

// File: rtl/quicksort_dp_ram.sv
// 32x8 dual-port array: reset loads the constant table, masked writes,
// registered reads that hold their value when not enabled.
module quicksort_dp_ram
  import quicksort_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              a_re,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [DATA_W-1:0] a_mask,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_re,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [DATA_W-1:0] b_mask,
  output logic [DATA_W-1:0] b_rdata
);
  logic [DATA_W-1:0] mem_q [N];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  // Storage and read registers; port b is written last so it wins a collision.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        mem_q[k] <= init_val(ADDR_W'(k));
      end
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_re) a_rdata_q <= mem_q[a_addr];
      if (b_re) b_rdata_q <= mem_q[b_addr];
      if (a_we) mem_q[a_addr] <= (a_wdata & a_mask) | (mem_q[a_addr] & ~a_mask);
      if (b_we) mem_q[b_addr] <= (b_wdata & b_mask) | (mem_q[b_addr] & ~b_mask);
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
endmodule

// File: rtl/quicksort_main.sv
// In-place iterative quicksort (Lomuto partition) over a 32-byte array, with
// a two-channel slave port that reaches the array only while idle.
module quicksort_main
  import quicksort_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start_port,
  input  logic [1:0]  S_oe_ram,
  input  logic [1:0]  S_we_ram,
  input  logic [13:0] S_addr_ram,
  input  logic [15:0] S_Wdata_ram,
  input  logic [7:0]  S_data_ram_size,
  input  logic [15:0] M_Rdata_ram,
  input  logic [1:0]  M_DataRdy,
  output logic        done_port,
  output logic [15:0] Sout_Rdata_ram,
  output logic [1:0]  Sout_DataRdy,
  output logic [1:0]  Mout_oe_ram,
  output logic [1:0]  Mout_we_ram,
  output logic [13:0] Mout_addr_ram,
  output logic [15:0] Mout_Wdata_ram,
  output logic [7:0]  Mout_data_ram_size
);
  state_e            state_q, state_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [ADDR_W-1:0] lo_q, lo_d, hi_q, hi_d, i_q, i_d, j_q, j_d;
  logic [DATA_W-1:0] pivot_q, pivot_d;
  logic              done_q, done_d;
  logic [1:0]        ack_q, ack_d, rd_q, rd_d;

  stack_entry_t      stack_q [N];
  stack_entry_t      top_s, push_r_val, push_l_val;
  logic              push_r_en, push_l_en;
  logic [ADDR_W-1:0] push_l_idx;

  logic              a_re, a_we, b_re, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata, a_mask, b_mask, a_rdata, b_rdata;

  logic [6:0]        s_addr0, s_addr1;
  logic [ADDR_W-1:0] s_off0, s_off1;
  logic              s_go0, s_go1;
  logic              unused_m_s;

  assign unused_m_s = ^{M_Rdata_ram, M_DataRdy};

  // Slave decode: an access needs an in-window address and exactly one of oe/we.
  assign s_addr0 = S_addr_ram[6:0];
  assign s_addr1 = S_addr_ram[13:7];
  assign s_off0  = ADDR_W'(s_addr0 - MEM_var_28860_28869);
  assign s_off1  = ADDR_W'(s_addr1 - MEM_var_28860_28869);
  assign s_go0   = (s_addr0 >= MEM_var_28860_28869) &&
                   (s_addr0 < (MEM_var_28860_28869 + 7'd32)) && (S_oe_ram[0] ^ S_we_ram[0]);
  assign s_go1   = (s_addr1 >= MEM_var_28860_28869) &&
                   (s_addr1 < (MEM_var_28860_28869 + 7'd32)) && (S_oe_ram[1] ^ S_we_ram[1]);

  assign top_s      = stack_q[ADDR_W'(sp_q - 6'd1)];
  assign push_l_idx = ADDR_W'(sp_q) + (push_r_en ? 5'd1 : 5'd0);

  quicksort_dp_ram u_ram (
    .clock   (clock),
    .reset   (reset),
    .a_re    (a_re),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .a_mask  (a_mask),
    .a_rdata (a_rdata),
    .b_re    (b_re),
    .b_we    (b_we),
    .b_addr  (b_addr),
    .b_wdata (b_wdata),
    .b_mask  (b_mask),
    .b_rdata (b_rdata)
  );

  // Next-state, RAM port and stack-push control.
  always_comb begin
    state_d = state_q;  sp_d = sp_q;  lo_d = lo_q;  hi_d = hi_q;
    i_d = i_q;  j_d = j_q;  pivot_d = pivot_q;  done_d = 1'b0;
    ack_d = 2'b00;  rd_d = 2'b00;
    push_r_en = 1'b0;  push_r_val = '0;  push_l_en = 1'b0;  push_l_val = '0;
    a_re = 1'b0;  a_we = 1'b0;  a_addr = '0;  a_wdata = '0;  a_mask = 8'hFF;
    b_re = 1'b0;  b_we = 1'b0;  b_addr = '0;  b_wdata = '0;  b_mask = 8'hFF;
    case (state_q)
      ST_IDLE: begin
        if (s_go0) begin
          a_re = S_oe_ram[0];  a_we = S_we_ram[0];  a_addr = s_off0;
          a_wdata = S_Wdata_ram[7:0];  a_mask = size_mask(S_data_ram_size[3:0]);
          ack_d[0] = 1'b1;  rd_d[0] = S_oe_ram[0];
        end else begin
          ack_d[0] = 1'b0;  rd_d[0] = 1'b0;
        end
        if (s_go1) begin
          b_re = S_oe_ram[1];  b_we = S_we_ram[1];  b_addr = s_off1;
          b_wdata = S_Wdata_ram[15:8];  b_mask = size_mask(S_data_ram_size[7:4]);
          ack_d[1] = 1'b1;  rd_d[1] = S_oe_ram[1];
        end else begin
          ack_d[1] = 1'b0;  rd_d[1] = 1'b0;
        end
        if (start_port) state_d = ST_PUSH_INIT;
        else            state_d = ST_IDLE;
      end
      ST_PUSH_INIT: begin
        push_r_en = 1'b1;  push_r_val.lo = 5'd0;  push_r_val.hi = 5'd31;
        sp_d = sp_q + 6'd1;
        state_d = ST_POP;
      end
      ST_POP: begin
        if (sp_q == 6'd0) begin
          state_d = ST_DONE;
        end else begin
          sp_d = sp_q - 6'd1;  lo_d = top_s.lo;  hi_d = top_s.hi;
          if (top_s.lo >= top_s.hi) begin
            state_d = ST_POP;
          end else begin
            a_re = 1'b1;  a_addr = top_s.hi;
            state_d = ST_PART_SETUP;
          end
        end
      end
      ST_PART_SETUP: begin
        pivot_d = a_rdata;  i_d = lo_q;  j_d = lo_q;
        a_re = 1'b1;  a_addr = lo_q;  b_re = 1'b1;  b_addr = lo_q;
        state_d = ST_PART_LOOP;
      end
      // Here a_rdata = A[i] and b_rdata = A[j]; with j == hi the held pair feeds PART_END.
      ST_PART_LOOP: begin
        if (j_q == hi_q) begin
          state_d = ST_PART_END;
        end else if (b_rdata <= pivot_q) begin
          a_we = 1'b1;  a_addr = i_q;  a_wdata = b_rdata;
          b_we = 1'b1;  b_addr = j_q;  b_wdata = a_rdata;
          i_d = i_q + 5'd1;  j_d = j_q + 5'd1;
          state_d = ST_SWAP;
        end else begin
          a_re = 1'b1;  a_addr = i_q;  b_re = 1'b1;  b_addr = j_q + 5'd1;
          j_d = j_q + 5'd1;
          state_d = ST_PART_LOOP;
        end
      end
      ST_SWAP: begin
        a_re = 1'b1;  a_addr = i_q;  b_re = 1'b1;  b_addr = j_q;
        state_d = ST_PART_LOOP;
      end
      ST_PART_END: begin
        a_we = 1'b1;  a_addr = i_q;  a_wdata = b_rdata;
        b_we = 1'b1;  b_addr = hi_q;  b_wdata = a_rdata;
        state_d = ST_PUSH_SUB;
      end
      ST_PUSH_SUB: begin
        if (({1'b0, i_q} + 6'd1) < {1'b0, hi_q}) begin
          push_r_en = 1'b1;  push_r_val.lo = i_q + 5'd1;  push_r_val.hi = hi_q;
        end else begin
          push_r_en = 1'b0;
        end
        if (({1'b0, lo_q} + 6'd1) < {1'b0, i_q}) begin
          push_l_en = 1'b1;  push_l_val.lo = lo_q;  push_l_val.hi = i_q - 5'd1;
        end else begin
          push_l_en = 1'b0;
        end
        sp_d = sp_q + SP_W'(push_r_en) + SP_W'(push_l_en);
        state_d = ST_POP;
      end
      ST_DONE: begin
        done_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;  sp_q <= '0;  lo_q <= '0;  hi_q <= '0;
      i_q <= '0;  j_q <= '0;  pivot_q <= '0;  done_q <= 1'b0;
      ack_q <= 2'b00;  rd_q <= 2'b00;
    end else begin
      state_q <= state_d;  sp_q <= sp_d;  lo_q <= lo_d;  hi_q <= hi_d;
      i_q <= i_d;  j_q <= j_d;  pivot_q <= pivot_d;  done_q <= done_d;
      ack_q <= ack_d;  rd_q <= rd_d;
    end
  end

  // Stack entries need no reset: sp_q alone says which are live.
  always_ff @(posedge clock) begin
    if (push_r_en) stack_q[ADDR_W'(sp_q)] <= push_r_val;
    if (push_l_en) stack_q[push_l_idx]    <= push_l_val;
  end

  assign done_port          = done_q;
  assign Sout_DataRdy       = ack_q;
  assign Sout_Rdata_ram     = {(rd_q[1] ? b_rdata : 8'd0), (rd_q[0] ? a_rdata : 8'd0)};
  assign Mout_oe_ram        = 2'b00;
  assign Mout_we_ram        = 2'b00;
  assign Mout_addr_ram      = 14'd0;
  assign Mout_Wdata_ram     = 16'd0;
  assign Mout_data_ram_size = 8'd0;
endmodule

// File: tb/tb_quicksort_main.sv
// Directed + randomized bench for quicksort_main against a behavioural array model.
module tb_quicksort_main;
  logic        clock = 1'b0;
  logic        reset, start_port;
  logic [1:0]  S_oe_ram, S_we_ram, M_DataRdy;
  logic [13:0] S_addr_ram;
  logic [15:0] S_Wdata_ram, M_Rdata_ram;
  logic [7:0]  S_data_ram_size;
  logic        done_port;
  logic [15:0] Sout_Rdata_ram, Mout_Wdata_ram;
  logic [1:0]  Sout_DataRdy, Mout_oe_ram, Mout_we_ram;
  logic [13:0] Mout_addr_ram;
  logic [7:0]  Mout_data_ram_size;

  logic [7:0]  ref_mem [32];
  int          total = 0;
  int          passed = 0;

  always #5 clock = ~clock;

  quicksort_main dut (
    .clock(clock), .reset(reset), .start_port(start_port),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy),
    .done_port(done_port), .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
    .Mout_oe_ram(Mout_oe_ram), .Mout_we_ram(Mout_we_ram), .Mout_addr_ram(Mout_addr_ram),
    .Mout_Wdata_ram(Mout_Wdata_ram), .Mout_data_ram_size(Mout_data_ram_size)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    start_port = 1'b0;  S_oe_ram = 2'b00;  S_we_ram = 2'b00;  S_addr_ram = 14'd0;
    S_Wdata_ram = 16'd0;  S_data_ram_size = 8'd0;  M_Rdata_ram = 16'd0;  M_DataRdy = 2'b00;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) ref_mem[k] = 8'((90 + 37 * k) % 256);
  endtask

  task automatic model_sort();
    logic [7:0] q [$];
    q = {};
    for (int k = 0; k < 32; k++) q.push_back(ref_mem[k]);
    q.sort();
    for (int k = 0; k < 32; k++) ref_mem[k] = q[k];
  endtask

  // One slave cycle on both channels; expectations come from the model before the write.
  task automatic slave_cycle(input string tag, input logic [1:0] oe, input logic [1:0] we,
                             input logic [6:0] a0, input logic [6:0] a1,
                             input logic [7:0] d0, input logic [7:0] d1,
                             input logic [3:0] z0, input logic [3:0] z1);
    logic [6:0] addr [2];
    logic [7:0] wd [2];
    logic [3:0] sz [2];
    logic       exp_rdy [2];
    logic [7:0] exp_dat [2];
    logic [7:0] m;
    int         off;
    addr[0] = a0;  addr[1] = a1;  wd[0] = d0;  wd[1] = d1;  sz[0] = z0;  sz[1] = z1;
    for (int c = 0; c < 2; c++) begin
      exp_rdy[c] = (addr[c] >= 7'd32) && (addr[c] < 7'd64) && (oe[c] != we[c]);
      exp_dat[c] = 8'd0;
      if (exp_rdy[c] && oe[c]) begin
        off = int'(addr[c]) - 32;
        exp_dat[c] = ref_mem[off];
      end
    end
    @(negedge clock);
    S_oe_ram = oe;  S_we_ram = we;  S_addr_ram = {a1, a0};
    S_Wdata_ram = {d1, d0};  S_data_ram_size = {z1, z0};
    @(negedge clock);
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      check($sformatf("%s rdy%0d", tag, c), 32'(Sout_DataRdy[c]), 32'(exp_rdy[c]));
      check($sformatf("%s data%0d", tag, c), 32'(Sout_Rdata_ram[8*c +: 8]), 32'(exp_dat[c]));
    end
    for (int c = 0; c < 2; c++) begin
      if (exp_rdy[c] && we[c]) begin
        off = int'(addr[c]) - 32;
        m = (sz[c] >= 4'd8) ? 8'hFF : 8'((1 << sz[c]) - 1);
        ref_mem[off] = (wd[c] & m) | (ref_mem[off] & ~m);
      end
    end
  endtask

  task automatic readback(input string tag);
    for (int k = 0; k < 32; k += 2)
      slave_cycle($sformatf("%s[%0d]", tag, k), 2'b11, 2'b00, 7'(32 + k), 7'(33 + k),
                  8'd0, 8'd0, 4'd8, 4'd8);
  endtask

  task automatic write_byte(input string tag, input int k, input logic [7:0] v);
    if (k % 2 == 0) slave_cycle(tag, 2'b00, 2'b01, 7'(32 + k), 7'd0, v, 8'd0, 4'd8, 4'd0);
    else            slave_cycle(tag, 2'b00, 2'b10, 7'd0, 7'(32 + k), 8'd0, v, 4'd0, 4'd8);
  endtask

  task automatic start_sort();
    @(negedge clock);  start_port = 1'b1;
    @(negedge clock);  start_port = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int elapsed);
    int pulses = 0;
    int first = -1;
    for (int cyc = 1; cyc <= 4200; cyc++) begin
      @(negedge clock);
      if (done_port === 1'b1) begin
        pulses++;
        if (first < 0) first = cyc + elapsed;
      end
      if (first >= 0 && cyc >= first - elapsed + 3) break;
    end
    check({tag, " done pulses"}, 32'(pulses), 32'd1);
    check({tag, " done in budget"}, 32'(first > 0 && first <= 4096), 32'd1);
  endtask

  task automatic sort_and_check(input string tag);
    start_sort();
    wait_done(tag, 1);
    model_sort();
    readback({tag, " rb"});
    check({tag, " mout"}, 32'(|{Mout_oe_ram, Mout_we_ram, Mout_addr_ram,
                                 Mout_Wdata_ram, Mout_data_ram_size}), 32'd0);
  endtask

  initial begin
    int pulses;
    logic [1:0] ch;
    logic [6:0] ra;
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    model_reset();
    check("rst done", 32'(done_port), 32'd0);
    check("rst mout", 32'(|{Mout_oe_ram, Mout_we_ram, Mout_addr_ram,
                            Mout_Wdata_ram, Mout_data_ram_size}), 32'd0);
    check("rst rdy", 32'(Sout_DataRdy), 32'd0);
    check("rst rdata", 32'(Sout_Rdata_ram), 32'd0);
    slave_cycle("init 32/33", 2'b11, 2'b00, 7'd32, 7'd33, 8'd0, 8'd0, 4'd8, 4'd8);

    sort_and_check("sort init");

    for (int k = 0; k < 32; k++) write_byte("wr desc", k, 8'(31 - k));
    sort_and_check("sort desc");

    for (int k = 0; k < 32; k++) write_byte("wr 55", k, 8'h55);
    sort_and_check("sort 55 a");
    sort_and_check("sort 55 b");

    slave_cycle("miss 31/64", 2'b11, 2'b00, 7'd31, 7'd64, 8'd0, 8'd0, 4'd8, 4'd8);
    slave_cycle("oe+we", 2'b11, 2'b11, 7'd35, 7'd36, 8'h12, 8'h34, 4'd8, 4'd8);
    slave_cycle("same addr", 2'b00, 2'b11, 7'd40, 7'd40, 8'hAA, 8'h11, 4'd8, 4'd8);
    slave_cycle("nibble wr", 2'b00, 2'b01, 7'd41, 7'd0, 8'hF3, 8'h00, 4'd4, 4'd0);
    slave_cycle("rd 40/41", 2'b11, 2'b00, 7'd40, 7'd41, 8'd0, 8'd0, 4'd8, 4'd8);

    for (int n = 0; n < 60; n++) begin
      ch = ($urandom_range(1, 0) == 0) ? 2'b01 : 2'b10;
      ra = 7'($urandom_range(71, 24));
      slave_cycle($sformatf("rnd %0d", n), ch & 2'($urandom), ch & 2'($urandom), ra, ra,
                  8'($urandom), 8'($urandom), 4'($urandom), 4'($urandom));
    end
    readback("rnd pre");
    sort_and_check("sort rnd");

    start_sort();
    repeat (20) @(negedge clock);
    S_we_ram = 2'b01;  S_oe_ram = 2'b10;  S_addr_ram = {7'd33, 7'd32};
    S_Wdata_ram = 16'h0000;  S_data_ram_size = 8'h88;
    @(negedge clock);
    idle_inputs();
    check("busy rdy", 32'(Sout_DataRdy), 32'd0);
    check("busy rdata", 32'(Sout_Rdata_ram), 32'd0);
    wait_done("busy wr", 22);
    model_sort();
    readback("busy rb");

    start_sort();
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (done_port === 1'b1) pulses++;
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (done_port === 1'b1) pulses++;
    end
    check("abort no done", 32'(pulses), 32'd0);
    model_reset();
    slave_cycle("abort rd 32", 2'b01, 2'b00, 7'd32, 7'd0, 8'd0, 8'd0, 4'd8, 4'd0);
    sort_and_check("sort after abort");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
